// File: rtl/tlb_refill_walker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tlb_refill_walker: Sv39 page-table walker that refills the fully          |
// | associative TLB. Optional macro PTW_AD_CHECK_EN adds leaf A/D faults.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tlb_refill_walker #(
  parameter int VPN_WIDTH   = 39,
  parameter int PPN_WIDTH   = 44,
  parameter int PADDR_WIDTH = 56
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   walk_req_valid,
  output logic                   walk_req_ready,
  input  logic [VPN_WIDTH-1:0]   walk_vpn,
  input  logic [15:0]            walk_asid,
  input  logic                   walk_is_store,
  input  logic [PPN_WIDTH-1:0]   satp_ppn,
  output logic                   walk_resp_valid,
  output logic                   walk_resp_fault,
  output logic [PPN_WIDTH-1:0]   walk_resp_ppn,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [PADDR_WIDTH-1:0] mem_req_addr,
  input  logic                   mem_resp_valid,
  input  logic [63:0]            mem_resp_data,
  output logic                   insert_valid,
  output logic [VPN_WIDTH-1:0]   insert_vpn,
  output logic [PPN_WIDTH-1:0]   insert_ppn,
  output logic [15:0]            insert_asid,
  input  logic                   invalidate_all,
  input  logic                   invalidate_by_asid,
  input  logic [15:0]            invalidate_asid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [VPN_WIDTH-1:0] vpn, vpn_nxt;
  logic [15:0]          asid, asid_nxt;
  logic                 is_store, is_store_nxt;
  logic [PPN_WIDTH-1:0] base, base_nxt;
  logic [PPN_WIDTH-1:0] result, result_nxt;
  logic [1:0]           level, level_nxt;
  logic                 stale, stale_nxt;
  logic                 fault, fault_nxt;

  logic                 pte_v, pte_r, pte_w, pte_x, pte_a, pte_d;
  logic [PPN_WIDTH-1:0] pte_ppn;
  logic                 leaf_misalign;
  logic [PPN_WIDTH-1:0] leaf_ppn;
  logic [8:0]           vpn_idx;
  logic                 inv_hit;
  logic                 ad_fault;
  logic                 unused_bits;

  assign pte_v   = mem_resp_data[0];
  assign pte_r   = mem_resp_data[1];
  assign pte_w   = mem_resp_data[2];
  assign pte_x   = mem_resp_data[3];
  assign pte_a   = mem_resp_data[6];
  assign pte_d   = mem_resp_data[7];
  assign pte_ppn = mem_resp_data[PPN_WIDTH+9:10];

  assign inv_hit = invalidate_all || (invalidate_by_asid && (invalidate_asid == asid));

`ifdef PTW_AD_CHECK_EN
  assign ad_fault    = !pte_a || (is_store && !pte_d);
  assign unused_bits = ^{mem_resp_data[63:54], mem_resp_data[9:8], mem_resp_data[5:4]};
`else
  assign ad_fault    = 1'b0;
  assign unused_bits = ^{mem_resp_data[63:54], mem_resp_data[9:8], mem_resp_data[5:4],
                         pte_a, pte_d, is_store};
`endif

  // Superpage leaves are flattened: low PPN bits come from the VPN.
  always_comb begin
    leaf_misalign = 1'b0;
    leaf_ppn      = pte_ppn;
    vpn_idx       = vpn[8:0];
    case (level)
      2'd2: begin
        leaf_misalign = |pte_ppn[17:0];
        leaf_ppn      = {pte_ppn[PPN_WIDTH-1:18], vpn[17:0]};
        vpn_idx       = vpn[26:18];
      end
      2'd1: begin
        leaf_misalign = |pte_ppn[8:0];
        leaf_ppn      = {pte_ppn[PPN_WIDTH-1:9], vpn[8:0]};
        vpn_idx       = vpn[17:9];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    vpn_nxt      = vpn;
    asid_nxt     = asid;
    is_store_nxt = is_store;
    base_nxt     = base;
    level_nxt    = level;
    stale_nxt    = stale;
    fault_nxt    = fault;
    result_nxt   = result;
    if (state != IDLE) stale_nxt = stale || inv_hit;
    case (state)
      IDLE: begin
        if (walk_req_valid && walk_req_ready) begin
          vpn_nxt      = walk_vpn;
          asid_nxt     = walk_asid;
          is_store_nxt = walk_is_store;
          base_nxt     = satp_ppn;
          level_nxt    = 2'd2;
          result_nxt   = '0;
          stale_nxt    = invalidate_all || (invalidate_by_asid && (invalidate_asid == walk_asid));
          fault_nxt    = |walk_vpn[VPN_WIDTH-1:27];
          state_nxt    = fault_nxt ? DONE : REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid) begin
          if (!pte_v || (!pte_r && pte_w)) begin
            fault_nxt = 1'b1;
            state_nxt = DONE;
          end else if (!pte_r && !pte_x) begin
            if (level == 2'd0) begin
              fault_nxt = 1'b1;
              state_nxt = DONE;
            end else begin
              base_nxt  = pte_ppn;
              level_nxt = level - 2'd1;
              state_nxt = REQ;
            end
          end else begin
            fault_nxt  = leaf_misalign || ad_fault;
            result_nxt = leaf_ppn;
            state_nxt  = DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      vpn      <= '0;
      asid     <= '0;
      is_store <= 1'b0;
      base     <= '0;
      result   <= '0;
      level    <= 2'd2;
      stale    <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= state_nxt;
      vpn      <= vpn_nxt;
      asid     <= asid_nxt;
      is_store <= is_store_nxt;
      base     <= base_nxt;
      result   <= result_nxt;
      level    <= level_nxt;
      stale    <= stale_nxt;
      fault    <= fault_nxt;
    end
  end

  // Outputs are held low while rst is asserted, whatever the state register holds.
  assign walk_req_ready  = (state == IDLE) && !rst;
  assign mem_req_valid   = (state == REQ) && !rst;
  assign mem_req_addr    = mem_req_valid ? {base, vpn_idx, 3'b000} : '0;
  assign walk_resp_valid = (state == DONE) && !rst;
  assign walk_resp_fault = walk_resp_valid && fault;
  assign walk_resp_ppn   = (walk_resp_valid && !fault) ? result : '0;
  assign insert_valid    = walk_resp_valid && !fault && !stale && !inv_hit;
  assign insert_vpn      = vpn;
  assign insert_ppn      = result;
  assign insert_asid     = asid;

endmodule
`default_nettype wire

// File: tb/tb_tlb_refill_walker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tlb_refill_walker: directed and random Sv39 walks checked against a     |
// | reference walk over a sparse page-table memory.                            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_tlb_refill_walker;

`ifdef PTW_AD_CHECK_EN
  localparam bit AD_EN = 1'b1;
`else
  localparam bit AD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        walk_req_valid, walk_req_ready;
  logic [38:0] walk_vpn;
  logic [15:0] walk_asid;
  logic        walk_is_store;
  logic [43:0] satp_ppn;
  logic        walk_resp_valid, walk_resp_fault;
  logic [43:0] walk_resp_ppn;
  logic        mem_req_valid, mem_req_ready;
  logic [55:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        insert_valid;
  logic [38:0] insert_vpn;
  logic [43:0] insert_ppn;
  logic [15:0] insert_asid;
  logic        invalidate_all, invalidate_by_asid;
  logic [15:0] invalidate_asid;

  always #5 clk = ~clk;

  tlb_refill_walker dut (
    .clk(clk), .rst(rst),
    .walk_req_valid(walk_req_valid), .walk_req_ready(walk_req_ready),
    .walk_vpn(walk_vpn), .walk_asid(walk_asid), .walk_is_store(walk_is_store),
    .satp_ppn(satp_ppn),
    .walk_resp_valid(walk_resp_valid), .walk_resp_fault(walk_resp_fault),
    .walk_resp_ppn(walk_resp_ppn),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .insert_valid(insert_valid), .insert_vpn(insert_vpn),
    .insert_ppn(insert_ppn), .insert_asid(insert_asid),
    .invalidate_all(invalidate_all), .invalidate_by_asid(invalidate_by_asid),
    .invalidate_asid(invalidate_asid)
  );

  int          errors = 0;
  int          checks = 0;
  logic [63:0] pmem [logic [55:0]];

  int          last_lat;
  int          last_reads;
  logic        last_fault;
  logic        last_ins;
  logic [43:0] last_ppn;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rd(input logic [55:0] a);
    return pmem.exists(a) ? pmem[a] : 64'd0;
  endfunction

  // Reference Sv39 walk: plain shift/mask arithmetic over the sparse memory.
  function automatic void model(input logic [43:0] satp, input logic [38:0] v, input logic st,
                                output logic f, output logic [43:0] p, output int n,
                                output logic [55:0] ad [3]);
    logic [43:0] b;
    logic [63:0] pte, ppn, mask, va;
    logic        ad_bad;
    b = satp; f = 1'b1; p = '0; n = 0;
    ad[0] = '0; ad[1] = '0; ad[2] = '0;
    va = 64'(v);
    if ((va >> 27) != 64'd0) return;
    for (int lvl = 2; lvl >= 0; lvl--) begin
      ad[n] = {b, 12'h000} + 56'(((va >> (9 * lvl)) & 64'h1ff) * 64'd8);
      pte = rd(ad[n]);
      n++;
      if (!pte[0] || (!pte[1] && pte[2])) return;
      ppn = (pte >> 10) & ((64'd1 << 44) - 64'd1);
      if (!pte[1] && !pte[3]) begin
        if (lvl == 0) return;
        b = ppn[43:0];
        continue;
      end
      mask = (64'd1 << (9 * lvl)) - 64'd1;
      if ((ppn & mask) != 64'd0) return;
      ad_bad = !pte[6] || (st && !pte[7]);
      if (AD_EN && ad_bad) return;
      f = 1'b0;
      p = 44'((ppn & ~mask) | (va & mask));
      return;
    end
  endfunction

  // inv_mode: 0 none, 1 matching ASID flush in first WAIT, 2 non-matching flush.
  task automatic run_walk(input string tag, input logic [38:0] v, input logic [15:0] a,
                          input logic st, input logic [43:0] satp, input int stall,
                          input int inv_mode);
    logic        ef, exp_stale, due, done, inv_sent;
    logic [43:0] ep;
    int          en, reads, cyc, stall_left, exp_lat;
    logic [55:0] ead [3];
    logic [55:0] due_addr, hold_addr;
    model(satp, v, st, ef, ep, en, ead);
    exp_lat   = (en == 0) ? 0 : 2 * en + stall;
    exp_stale = (inv_mode == 1) && (en > 0);
    @(negedge clk);
    chk({tag, ".ready"}, 64'(walk_req_ready), 64'd1);
    walk_req_valid = 1'b1; walk_vpn = v; walk_asid = a; walk_is_store = st; satp_ppn = satp;
    @(posedge clk); #1;
    walk_req_valid = 1'b0; walk_vpn = ~v; walk_asid = ~a; satp_ppn = ~satp;
    reads = 0; cyc = 0; stall_left = stall; due = 1'b0; done = 1'b0; inv_sent = 1'b0;
    due_addr = '0; hold_addr = '0;
    while (!done && cyc < 200) begin
      cyc++;
      mem_resp_valid = 1'b0; mem_resp_data = '0; mem_req_ready = 1'b0;
      invalidate_by_asid = 1'b0;
      if (walk_resp_valid) begin
        done       = 1'b1;
        last_lat   = cyc - 1;
        last_reads = reads;
        last_fault = walk_resp_fault;
        last_ins   = insert_valid;
        last_ppn   = walk_resp_ppn;
        chk({tag, ".latency"}, 64'(cyc - 1), 64'(exp_lat));
        chk({tag, ".reads"}, 64'(reads), 64'(en));
        chk({tag, ".fault"}, 64'(walk_resp_fault), 64'(ef));
        chk({tag, ".ppn"}, 64'(walk_resp_ppn), ef ? 64'd0 : 64'(ep));
        chk({tag, ".insert"}, 64'(insert_valid), 64'(!ef && !exp_stale));
        chk({tag, ".ready_done"}, 64'(walk_req_ready), 64'd0);
        if (!ef && !exp_stale) begin
          chk({tag, ".ins_vpn"}, 64'(insert_vpn), 64'(v));
          chk({tag, ".ins_ppn"}, 64'(insert_ppn), 64'(ep));
          chk({tag, ".ins_asid"}, 64'(insert_asid), 64'(a));
        end
        @(posedge clk); #1;
        chk({tag, ".one_pulse"}, 64'(walk_resp_valid), 64'd0);
      end else begin
        if (due) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = rd(due_addr);
          due = 1'b0;
          if (inv_mode != 0 && !inv_sent) begin
            invalidate_by_asid = 1'b1;
            invalidate_asid    = (inv_mode == 1) ? a : (a ^ 16'h8001);
            inv_sent = 1'b1;
          end
        end
        if (mem_req_valid) begin
          if (stall_left > 0) begin
            if (stall_left == stall) hold_addr = mem_req_addr;
            else chk({tag, ".addr_stable"}, 64'(mem_req_addr), 64'(hold_addr));
            stall_left--;
            mem_resp_valid = 1'b1;
            mem_resp_data  = 64'h0000_0000_2AF3_78CF;
          end else begin
            if (reads < en) chk($sformatf("%s.addr%0d", tag, reads), 64'(mem_req_addr), 64'(ead[reads]));
            else chk({tag, ".extra_req"}, 64'(reads + 1), 64'(en));
            mem_req_ready = 1'b1;
            due = 1'b1;
            due_addr = mem_req_addr;
            reads++;
          end
        end
        @(posedge clk); #1;
      end
    end
    chk({tag, ".resp_seen"}, 64'(done), 64'd1);
    mem_resp_valid = 1'b0; mem_req_ready = 1'b0; invalidate_by_asid = 1'b0;
  endtask

  task automatic set_4k_tables();
    pmem.delete();
    pmem[56'h10_0080] = 64'h0000_0000_0008_0001;
    pmem[56'h20_0040] = 64'h0000_0000_000C_0001;
    pmem[56'h30_0018] = 64'h0000_0000_2000_04CF;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [38:0] v;
    logic [43:0] s, b;
    logic [63:0] pte;
    logic [55:0] ad;
    int          k;
    rst = 1'b1; walk_req_valid = 1'b0; walk_vpn = '0; walk_asid = '0; walk_is_store = 1'b0;
    satp_ppn = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    invalidate_all = 1'b0; invalidate_by_asid = 1'b0; invalidate_asid = '0;
    last_lat = 0; last_reads = 0; last_fault = 1'b0; last_ins = 1'b0; last_ppn = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.ready", 64'(walk_req_ready), 64'd0);
    chk("rst.resp", 64'(walk_resp_valid), 64'd0);
    chk("rst.mem_req", 64'(mem_req_valid), 64'd0);
    chk("rst.insert", 64'(insert_valid), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst.ready", 64'(walk_req_ready), 64'd1);
    chk("post_rst.addr", 64'(mem_req_addr), 64'd0);
    chk("post_rst.ppn", 64'(walk_resp_ppn), 64'd0);

    // 4 KiB three-level walk
    set_4k_tables();
    run_walk("walk4k", 39'h00_0040_1003, 16'h1234, 1'b0, 44'h100, 0, 0);
    chk("walk4k.lat6", 64'(last_lat), 64'd6);
    chk("walk4k.ppn_lit", 64'(last_ppn), 64'h80001);

    run_walk("bp", 39'h00_0040_1003, 16'h1234, 1'b0, 44'h100, 5, 0);
    chk("bp.lat11", 64'(last_lat), 64'd11);
    chk("bp.ppn_lit", 64'(last_ppn), 64'h80001);

    run_walk("stale_hit", 39'h00_0040_1003, 16'h00A5, 1'b0, 44'h100, 0, 1);
    chk("stale_hit.ins", 64'(last_ins), 64'd0);
    run_walk("stale_miss", 39'h00_0040_1003, 16'h00A5, 1'b0, 44'h100, 0, 2);
    chk("stale_miss.ins", 64'(last_ins), 64'd1);

    // 1 GiB superpage, aligned then misaligned
    pmem.delete();
    pmem[56'h10_0028] = 64'h0000_0000_1000_00CF;
    run_walk("giga", 39'h00_0015_2345, 16'h0007, 1'b0, 44'h100, 0, 0);
    chk("giga.ppn_lit", 64'(last_ppn), 64'h52345);
    chk("giga.reads1", 64'(last_reads), 64'd1);
    pmem[56'h10_0028] = 64'h0000_0000_1000_04CF;
    run_walk("giga_mis", 39'h00_0015_2345, 16'h0007, 1'b0, 44'h100, 0, 0);
    chk("giga_mis.fault", 64'(last_fault), 64'd1);

    // Faults
    pmem.delete();
    pmem[56'h10_0080] = 64'h0000_0000_0008_0001;
    run_walk("l1_invalid", 39'h00_0040_1003, 16'h0011, 1'b0, 44'h100, 0, 0);
    chk("l1_invalid.fault", 64'(last_fault), 64'd1);
    pmem[56'h10_0080] = 64'h0000_0000_0000_0005;
    run_walk("r0w1", 39'h00_0040_1003, 16'h0012, 1'b0, 44'h100, 0, 0);
    chk("r0w1.fault", 64'(last_fault), 64'd1);
    set_4k_tables();
    pmem[56'h30_0018] = 64'h0000_0000_0040_0001;
    run_walk("ptr_l0", 39'h00_0040_1003, 16'h0013, 1'b0, 44'h100, 0, 0);
    chk("ptr_l0.fault", 64'(last_fault), 64'd1);
    run_walk("vpn_hi", 39'h00_4000_1003, 16'h0014, 1'b0, 44'h100, 0, 0);
    chk("vpn_hi.fault", 64'(last_fault), 64'd1);
    chk("vpn_hi.reads0", 64'(last_reads), 64'd0);

    // A=1, D=0 leaf
    set_4k_tables();
    pmem[56'h30_0018] = 64'h0000_0000_2000_0447;
    run_walk("ad_store", 39'h00_0040_1003, 16'h0015, 1'b1, 44'h100, 0, 0);
    chk("ad_store.fault", 64'(last_fault), 64'(AD_EN));
    run_walk("ad_load", 39'h00_0040_1003, 16'h0015, 1'b0, 44'h100, 0, 0);
    chk("ad_load.fault", 64'(last_fault), 64'd0);

    // Reset while waiting for a PTE, then a late response
    set_4k_tables();
    @(negedge clk);
    walk_req_valid = 1'b1; walk_vpn = 39'h00_0040_1003; walk_asid = 16'h0099; satp_ppn = 44'h100;
    @(posedge clk); #1;
    walk_req_valid = 1'b0;
    chk("rstwait.req", 64'(mem_req_valid), 64'd1);
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    chk("rstwait.in_wait", 64'(mem_req_valid), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstwait.ready_in_rst", 64'(walk_req_ready), 64'd0);
    rst = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h0000_0000_2000_04CF;
    #1;
    chk("rstwait.ready_after", 64'(walk_req_ready), 64'd1);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rstwait.no_resp%0d", i), 64'(walk_resp_valid), 64'd0);
      chk($sformatf("rstwait.no_ins%0d", i), 64'(insert_valid), 64'd0);
      @(posedge clk); #1;
    end

    // Random page tables
    for (int i = 0; i < 60; i++) begin
      pmem.delete();
      v = {12'h000, 27'($urandom)};
      if ($urandom_range(0, 9) == 0) v[27 + $urandom_range(0, 11)] = 1'b1;
      s = {12'($urandom), $urandom};
      b = s;
      for (int lvl = 2; lvl >= 0; lvl--) begin
        ad  = {b, 12'h000} + 56'(((64'(v) >> (9 * lvl)) & 64'h1ff) * 64'd8);
        pte = {$urandom, $urandom};
        k   = $urandom_range(0, 9);
        if (k < 5) begin
          pte[3:0] = 4'b0001;
          pmem[ad] = pte;
          b = pte[53:10];
        end else if (k < 9) begin
          pte[0] = 1'b1;
          if (!pte[1]) begin pte[2] = 1'b0; pte[3] = 1'b1; end
          if ($urandom_range(0, 2) != 0) begin
            if (lvl == 2) pte[27:10] = '0;
            else if (lvl == 1) pte[18:10] = '0;
          end
          pmem[ad] = pte;
          break;
        end else begin
          pmem[ad] = pte;
          break;
        end
      end
      run_walk($sformatf("rnd%0d", i), v, 16'($urandom), 1'($urandom), s,
               int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tlb_refill_walker.md
Name: tlb_refill_walker

Overview:
- Sv39 hardware page-table walker; the refill side of the fully associative TLB.
- On a TLB miss the MMU hands it a VPN. It reads up to three PTEs over a single-outstanding memory read port.
- It returns the translation or a page fault to the MMU.
- On success it drives the TLB insert interface (insert_valid/vpn/ppn/asid) directly, with widths matching the TLB.

Parameters:
- VPN_WIDTH, 39: walk_vpn/insert_vpn width. Only bits [26:0] index tables; bits above 26 must be zero.
- PPN_WIDTH, 44: satp_ppn, insert_ppn, walk_resp_ppn width. Sv39 fixes 44.
- PADDR_WIDTH, 56: mem_req_addr width. Equals PPN_WIDTH+12.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- walk_req_valid  in  1  MMU miss request.
- walk_req_ready  out  1  walker can accept a request.
- walk_vpn  in  VPN_WIDTH  missing VPN.
- walk_asid  in  16  ASID of the request.
- walk_is_store  in  1  access is a store (used only by the optional feature).
- satp_ppn  in  PPN_WIDTH  root page-table PPN; sampled at accept.
- walk_resp_valid  out  1  one-cycle result pulse.
- walk_resp_fault  out  1  page fault; qualified by walk_resp_valid.
- walk_resp_ppn  out  PPN_WIDTH  final 4 KiB-granular PPN; 0 on fault.
- mem_req_valid  out  1  PTE read request.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  PADDR_WIDTH  PTE physical address.
- mem_resp_valid  in  1  PTE data valid.
- mem_resp_data  in  64  PTE.
- insert_valid  out  1  TLB fill strobe.
- insert_vpn  out  VPN_WIDTH  fill VPN.
- insert_ppn  out  PPN_WIDTH  fill PPN.
- insert_asid  out  16  fill ASID.
- invalidate_all  in  1  TLB flush-all, snooped.
- invalidate_by_asid  in  1  TLB flush-by-ASID, snooped.
- invalidate_asid  in  16  ASID for flush-by-ASID.

Behaviour:
- Reset: synchronous, active-high.
  - State goes to IDLE; level=2; stale=0.
  - All outputs 0, except walk_req_ready=1 from the cycle after rst deasserts.
  - Reset mid-walk abandons the walk: no response, no insert. A late mem_resp_valid is ignored.
- Registered state: vpn, asid, is_store, base PPN, level (2..0), stale.
- FSM IDLE / REQ / WAIT / DONE.
- IDLE:
  - walk_req_ready=1.
  - On valid&ready, latch vpn, asid, is_store; base=satp_ppn; level=2; stale=0.
  - If walk_vpn[VPN_WIDTH-1:27] != 0, go to DONE with fault, without any memory access. Otherwise go to REQ.
- REQ:
  - mem_req_valid=1, mem_req_addr={base, vpn[9*level+8 : 9*level], 3'b000}.
  - Address is held stable until mem_req_ready; then go to WAIT.
- WAIT:
  - On mem_resp_valid, decode the PTE: V=bit0, R=1, W=2, X=3, A=6, D=7, PPN=[53:10].
  - mem_resp_valid is ignored in any other state.
  - Decode outcomes, in order:
    - V=0, or (R=0 and W=1): fault, go to DONE.
    - Pointer (R=0, X=0): if level=0, fault, go to DONE. Else base=PTE.PPN, level-=1, go to REQ.
    - Leaf (R or X) at level 2: PPN[17:0] must be 0, else fault. Result={PPN[43:18], vpn[17:0]}.
    - Leaf at level 1: PPN[8:0] must be 0, else fault. Result={PPN[43:9], vpn[8:0]}.
    - Leaf at level 0: result=PPN.
    - Superpages are thereby flattened to a 4 KiB entry, since the TLB holds no page size.
- DONE (exactly one cycle, then IDLE):
  - walk_resp_valid=1, with walk_resp_fault and walk_resp_ppn.
  - insert_valid=1 only if no fault and stale=0. insert_vpn=latched vpn, insert_ppn=result, insert_asid=latched asid.
  - walk_req_ready=0 in DONE. A new request is accepted the next cycle at the earliest.
- Stale rule:
  - stale is set in any non-IDLE state when invalidate_all=1, or invalidate_by_asid=1 with invalidate_asid==latched asid.
  - An invalidate in the accept cycle or in the DONE cycle also counts; in DONE it suppresses that cycle's insert.
  - A stale walk still returns its response to the MMU but never fills the TLB.
- Latency (mem_req_ready=1, response one cycle after request):
  - Accept at cycle 0; 3-level walk gives walk_resp_valid at cycle 6.
  - Each level adds 2 cycles.
- Only one walk is outstanding; no queueing.

Optional Feature:
- Macro: PTW_AD_CHECK_EN.
- Defined: a leaf with A=0 faults; a leaf with walk_is_store=1 and D=0 faults. Checked after the alignment check.
- Undefined: A/D bits ignored; walk_is_store unused.

Test Plan:
- 4 KiB walk: satp_ppn=0x100, vpn=0x0_0040_1003, ready always 1.
  - Required mem_req_addr sequence: 0x100_000+8*vpn2, then L1 and L0 addresses from returned PTE PPNs.
  - L0 PTE=0x0000_0000_2000_04CF (PPN=0x80001).
  - Required: walk_resp_valid at cycle 6, fault=0, ppn=0x80001, insert_valid same cycle, insert_asid=latched asid.
- 1 GiB superpage: L2 leaf PTE with PPN=0x40000, vpn[17:0]=0x12345.
  - Required: one memory read, insert_ppn=0x52345.
  - Same test with PPN=0x40001: fault=1, insert_valid=0, walk_resp_ppn=0.
- Faults, each giving fault=1 and no insert:
  - V=0 PTE at L1.
  - R=0/W=1 PTE.
  - Pointer PTE at level 0.
  - vpn bit 30 set, which also gives zero memory requests.
- Backpressure: hold mem_req_ready=0 for 5 cycles.
  - Required: mem_req_addr stable throughout; mem_resp_valid pulsed during REQ is ignored; result is unchanged but 5 cycles later.
- Stale and reset:
  - invalidate_by_asid matching the walk ASID during WAIT: walk_resp_valid=1, insert_valid=0.
  - Non-matching ASID: insert occurs.
  - rst in WAIT, then a late mem_resp_valid: no walk_resp_valid; walk_req_ready=1 the cycle after reset.
- PTW_AD_CHECK_EN: leaf with A=1, D=0.
  - walk_is_store=1: fault=1 when defined, fault=0 when undefined.
  - walk_is_store=0: fault=0 in both builds.
